if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the 5-stage miniRV pipeline.
- Holds the PC and drives the combinational IROM address. Captures the returned instruction into IF/ID.
- Honours the load-use stall outputs of the data hazard detection unit and the branch/jump redirect raised in EX.
- Feeds pc/inst/valid into the ID stage, where the hazard unit consumes rR1/rR2.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (byte address, word-aligned).
NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted into IF/ID on reset or flush.

Ports:
cpu_clk  input  1  single clock, rising edge.
cpu_rst  input  1  asynchronous reset, active-high.
pipeline_stop_PC  input  1  from hazard unit: hold PC this cycle.
pipeline_stop_REG_IF_ID  input  1  from hazard unit: hold IF/ID this cycle.
redirect_EX  input  1  branch taken / jal / jalr resolved in EX.
redirect_pc_EX  input  32  redirect target byte address.
irom_addr  output  32  current fetch PC (pc_IF); combinational from the PC register.
irom_inst  input  32  instruction at irom_addr; same-cycle combinational read.
pc_ID  output  32  PC of the instruction in ID.
pc4_ID  output  32  pc_ID + 4 (for jal/jalr link value).
inst_ID  output  32  instruction in ID.
valid_ID  output  1  1 = inst_ID is a real fetched instruction; 0 = bubble.
stall_cnt  output  32  cycles in which the PC was held by a stall.
flush_cnt  output  32  cycles in which a redirect flushed IF/ID.

Behaviour:
- Reset (async, any time, including mid-stall or mid-redirect):
  - pc_IF = RESET_PC
  - pc_ID = 0, pc4_ID = 0, inst_ID = NOP_INST, valid_ID = 0
  - stall_cnt = 0, flush_cnt = 0
- After reset deasserts, the first rising edge captures irom_inst at RESET_PC into IF/ID.
- PC update at each rising edge, in priority order:
  1. redirect_EX = 1: pc_IF <= {redirect_pc_EX[31:2], 2'b00}. Low two bits are forced to zero.
  2. else pipeline_stop_PC = 1: pc_IF holds.
  3. else: pc_IF <= pc_IF + 4, modulo 2^32. 0xFFFF_FFFC wraps to 0x0000_0000.
- IF/ID update at each rising edge, in priority order:
  1. redirect_EX = 1: inst_ID <= NOP_INST, valid_ID <= 0, pc_ID/pc4_ID <= 0. This flushes the wrong-path instruction.
  2. else pipeline_stop_REG_IF_ID = 1: all IF/ID outputs hold.
  3. else: pc_ID <= pc_IF, pc4_ID <= pc_IF + 4, inst_ID <= irom_inst, valid_ID <= 1.
- Redirect always wins over a simultaneous stall. The branch in EX is older than the load-use victim in ID, so the stalled instruction is wrong-path and is discarded.
- pipeline_stop_PC and pipeline_stop_REG_IF_ID are obeyed independently. Asserting only one is legal and is not merged with the other.
- Latency: the instruction at address A appears on inst_ID one edge after irom_addr = A, absent stall or flush.
- A redirect costs two bubbles. This block supplies the IF/ID bubble; the ID/EX flush belongs to the EX control logic.
- Counters:
  - stall_cnt += 1 on each edge where pipeline_stop_PC = 1 and redirect_EX = 0.
  - flush_cnt += 1 on each edge where redirect_EX = 1.
  - Both wrap modulo 2^32.
- irom_addr carries no register of its own beyond pc_IF. Word-index slicing for the IROM is done at the top level.

Decomposition:
- defines.vh gains `NOP_INST (32'h0000_0013) and `PC_STEP (32'd4). Parameters default to these.
- One natural sub-module: if_id_reg, the IF/ID register with flush > hold > load priority and the valid bit.
- The PC register, next-PC logic and counters stay in if_stage.

Test Plan:
1. Reset then 4 free-running cycles, with IROM[i] = 0x100+i:
   - irom_addr = 0, 4, 8, 0xC
   - inst_ID follows one cycle later: 0x100, 0x101, 0x102
   - valid_ID rises on the first edge
2. Load-use stall: pipeline_stop_PC = pipeline_stop_REG_IF_ID = 1 for 1 cycle at pc_IF = 0x8:
   - pc_IF stays 0x8 for 2 cycles
   - inst_ID holds 0x101 for 2 cycles
   - stall_cnt = 1
3. Redirect: redirect_EX = 1, redirect_pc_EX = 0x40 at pc_IF = 0xC:
   - next pc_IF = 0x40
   - inst_ID = 0x13, valid_ID = 0
   - following edge: inst_ID = IROM[0x40], flush_cnt = 1
4. Redirect and both stops asserted in the same cycle, target 0x23:
   - pc_IF = 0x20 (misaligned bits cleared)
   - IF/ID flushed
   - stall_cnt unchanged, flush_cnt += 1
5. Async reset asserted mid-clock during a stall:
   - outputs go immediately to pc_IF = RESET_PC, inst_ID = 0x13, valid_ID = 0, counters 0, with no clock edge needed
6. Force pc_IF = 0xFFFF_FFFC, free-run:
   - next pc_IF = 0x0000_0000
   - pc4_ID for that fetch = 0x0000_0000

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared constants, types and helpers for the miniRV instruction-fetch stage.
// Imported by the fetch top level and by the IF/ID register.
package if_stage_pkg;

    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        PC_REDIRECT,
        PC_HOLD,
        PC_ADVANCE
    } pc_sel_e;

    // Clearing the low bits keeps every fetch address word-aligned
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load.
// A flushed or reset register carries a NOP bubble with valid cleared.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        hold,
    input  logic [31:0] pc_in,
    input  logic [31:0] inst_in,
    output logic [31:0] pc_out,
    output logic [31:0] pc4_out,
    output logic [31:0] inst_out,
    output logic        valid_out
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_out    <= 32'd0;
            pc4_out   <= 32'd0;
            inst_out  <= NOP_INST;
            valid_out <= 1'b0;
        end else if (flush) begin
            pc_out    <= 32'd0;
            pc4_out   <= 32'd0;
            inst_out  <= NOP_INST;
            valid_out <= 1'b0;
        end else if (!hold) begin
            pc_out    <= pc_in;
            pc4_out   <= pc_in + PC_STEP;
            inst_out  <= inst_in;
            valid_out <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, stall/flush counters,
// and the IF/ID register feeding the decode stage.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        pipeline_stop_PC,
    input  logic        pipeline_stop_REG_IF_ID,
    input  logic        redirect_EX,
    input  logic [31:0] redirect_pc_EX,
    output logic [31:0] irom_addr,
    input  logic [31:0] irom_inst,
    output logic [31:0] pc_ID,
    output logic [31:0] pc4_ID,
    output logic [31:0] inst_ID,
    output logic        valid_ID,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    logic [31:0] pc_IF;
    logic [31:0] pc_next;
    pc_sel_e     pc_sel;

    // A redirect from EX is older than any load-use stall, so it always wins
    always_comb begin
        pc_sel = PC_ADVANCE;
        if (redirect_EX) begin
            pc_sel = PC_REDIRECT;
        end else if (pipeline_stop_PC) begin
            pc_sel = PC_HOLD;
        end
    end

    always_comb begin
        pc_next = pc_IF + PC_STEP;
        case (pc_sel)
            PC_REDIRECT: pc_next = word_align(redirect_pc_EX);
            PC_HOLD:     pc_next = pc_IF;
            PC_ADVANCE:  pc_next = pc_IF + PC_STEP;
            default:     pc_next = pc_IF + PC_STEP;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            pc_IF <= RESET_PC;
        end else begin
            pc_IF <= pc_next;
        end
    end

    // A stall that coincides with a redirect is not counted: the redirect discards it
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (pc_sel == PC_HOLD) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (pc_sel == PC_REDIRECT) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign irom_addr = pc_IF;

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk       (cpu_clk),
        .rst       (cpu_rst),
        .flush     (redirect_EX),
        .hold      (pipeline_stop_REG_IF_ID),
        .pc_in     (pc_IF),
        .inst_in   (irom_inst),
        .pc_out    (pc_ID),
        .pc4_out   (pc4_ID),
        .inst_out  (inst_ID),
        .valid_out (valid_ID)
    );

endmodule
